// File: rtl/exp_series_engine.sv
// Iterative Taylor-series evaluator for e^x (x in Q0.16, result in Q2.16).
// Each term alternates a multiply by x and a multiply by 1/i taken from an external reciprocal LUT.
module exp_series_engine #(
    parameter int N_TERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [15:0] lut_data,
    output logic [3:0]  lut_adr,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_X = 2'd1,
        MUL_R = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N_TERMS - 1);

    state_t      state_q;
    logic [3:0]  i_q;
    logic [15:0] x_q;
    logic [16:0] term_q;
    logic [17:0] sum_q;
    logic [17:0] result_q;
    logic        done_q;
    logic        busy_q;

    logic [32:0] prod_x;
    logic [32:0] prod_r;
    logic [16:0] term_x_d;
    logic [16:0] term_r_d;
    logic [17:0] sum_d;

    // Both products are 17x16; keeping bits [32:16] is the truncating >>16.
    assign prod_x   = 33'(term_q) * 33'(x_q);
    assign prod_r   = 33'(term_q) * 33'(lut_data);
    assign term_x_d = prod_x[32:16];
    assign term_r_d = prod_r[32:16];
    assign sum_d    = sum_q + {1'b0, term_r_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= 4'd0;
            x_q      <= 16'd0;
            term_q   <= 17'd0;
            sum_q    <= 18'd0;
            result_q <= 18'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= x_in;
                        term_q  <= 17'h10000;
                        sum_q   <= 18'h10000;
                        i_q     <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= MUL_X;
                    end
                end
                MUL_X: begin
                    term_q  <= term_x_d;
                    state_q <= MUL_R;
                end
                MUL_R: begin
                    term_q <= term_r_d;
                    sum_q  <= sum_d;
                    if (i_q == LAST_IDX) begin
                        result_q <= sum_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        i_q     <= i_q + 4'd1;
                        state_q <= MUL_X;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The LUT answers in the same cycle, so the address follows the registered state directly.
    assign lut_adr = (state_q == MUL_R) ? i_q : 4'd0;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: tb/tb_exp_series_engine.sv
// Directed bench for exp_series_engine: reciprocal LUT model, bit-exact series model,
// and hand-computed results for x = 0, 0.5 and 0.25.
module tb_exp_series_engine;

    localparam int N = 8;
    localparam int LAT = 2 * N;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x_in;
    logic [15:0] lut_data;
    logic [3:0]  lut_adr;
    logic        busy;
    logic        done;
    logic [17:0] result;

    int n_vec;
    int n_err;

    exp_series_engine #(.N_TERMS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_in     (x_in),
        .lut_data (lut_data),
        .lut_adr  (lut_adr),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] recip(input logic [3:0] a);
        if (a == 4'd0) return 16'hFFFF;
        return 16'(32'd65536 / (32'(a) + 32'd1));
    endfunction

    always_comb lut_data = recip(lut_adr);

    function automatic logic [17:0] model_exp(input logic [15:0] x);
        logic [16:0] term;
        logic [17:0] sum;
        logic [33:0] p;
        term = 17'h10000;
        sum  = 18'h10000;
        for (int k = 0; k < N; k++) begin
            p    = 34'(term) * 34'(x);
            term = p[32:16];
            p    = 34'(term) * 34'(recip(4'(k)));
            term = p[32:16];
            sum  = sum + {1'b0, term};
        end
        return sum;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic near(input logic [17:0] a, input logic [17:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = -d;
        return d <= 16;
    endfunction

    // Start a run, then track busy/lut_adr each cycle until done (bounded).
    task automatic run_op(input string tag, input logic [15:0] x, input logic [17:0] exp_res,
                          input int chk_t1, input logic [16:0] exp_t1,
                          input int chk_t2, input logic [16:0] exp_t2);
        int cyc;
        start = 1'b1;
        x_in  = x;
        @(posedge clk); #1;
        start = 1'b0;
        x_in  = ~x;
        cyc = 0;
        while (!done && cyc < 40) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_adr"}, 32'(lut_adr), (cyc % 2 == 1) ? 32'((cyc - 1) / 2) : 32'd0);
            if (chk_t1 != 0 && cyc == 1) chk({tag, "_term_mulx"}, 32'(dut.term_q), 32'(exp_t1));
            if (chk_t2 != 0 && cyc == 2) chk({tag, "_term_mulr0"}, 32'(dut.term_q), 32'(exp_t2));
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(LAT));
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int done_at;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        x_in  = 16'h0;

        // T1: reset
        repeat (2) @(posedge clk);
        #1;
        chk("t1_result", 32'(result), 32'd0);
        chk("t1_done", 32'(done), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_adr", 32'(lut_adr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T2: x=0
        run_op("t2", 16'h0000, 18'h10000, 1, 17'h0, 0, 17'h0);

        // T3: x=0.5
        chk("t3_model", 32'(model_exp(16'h8000)), 32'h1A60D);
        run_op("t3", 16'h8000, 18'h1A60D, 1, 17'h8000, 1, 17'h7FFF);
        chk("t3_near", 32'(near(result, 18'h1A614)), 32'd1);

        // T4: x just below 1
        run_op("t4", 16'hFFFF, model_exp(16'hFFFF), 0, 17'h0, 0, 17'h0);
        chk("t4_near", 32'(near(result, 18'h2B7E1)), 32'd1);
        chk("t4_bit17", 32'(result[17]), 32'd1);

        // T5: start mid-run ignored, then back-to-back start during done
        start = 1'b1;
        x_in  = 16'h8000;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        done_at  = 0;
        for (cyc = 1; cyc <= 24 && done_at == 0; cyc++) begin
            start = (cyc == 5);
            x_in  = (cyc == 5) ? 16'hFFFF : 16'h1234;
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
        end
        start = 1'b0;
        chk("t5_done_cycle", 32'(done_at), 32'(LAT));
        chk("t5_result", 32'(result), 32'h1A60D);
        start = 1'b1;
        x_in  = 16'h4000;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_b2b_busy", 32'(busy), 32'd1);
        done_cnt = 0;
        done_at  = 0;
        for (cyc = 1; cyc <= 24; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 8) chk("t5_b2b_hold", 32'(result), 32'h1A60D);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
            end
        end
        chk("t5_b2b_done_cycle", 32'(done_at), 32'(LAT));
        chk("t5_b2b_done_count", 32'(done_cnt), 32'd1);
        chk("t5_b2b_result", 32'(result), 32'h148B2);

        // T6: reset mid-run aborts, then a clean run at x=0.25
        start = 1'b1;
        x_in  = 16'h8000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_result", 32'(result), 32'd0);
        chk("t6_adr", 32'(lut_adr), 32'd0);
        chk("t6_state", 32'(dut.state_q), 32'd0);
        done_cnt = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        chk("t6_model", 32'(model_exp(16'h4000)), 32'h148B2);
        run_op("t6_run", 16'h4000, 18'h148B2, 0, 17'h0, 0, 17'h0);
        chk("t6_near", 32'(near(result, 18'h148B6)), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
